// File: rtl/elevator_pkg.sv
// Shared elevator definitions: FSM state encoding, floor codes, default tick counts
// and floor-mask helpers used by the scheduler.
package elevator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DOOR_OPEN = 2'd1,
      ST_MOVING    = 2'd2,
      ST_HOLD      = 2'd3
   } state_t;

   localparam logic [1:0] FLOOR_1 = 2'b01;
   localparam logic [1:0] FLOOR_2 = 2'b10;
   localparam logic [1:0] FLOOR_3 = 2'b11;

   localparam int DOOR_TICKS_DEFAULT   = 3;
   localparam int TRAVEL_TICKS_DEFAULT = 2;
   localparam int CNT_W                = 4;

   // Floor masks: bit i stands for floor i+1.
   function automatic logic [2:0] floor_mask(input logic [1:0] code);
      logic [2:0] m;
      case (code)
         FLOOR_1: m = 3'b001;
         FLOOR_2: m = 3'b010;
         FLOOR_3: m = 3'b100;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   function automatic logic [2:0] ahead_mask(input logic [1:0] code, input logic up);
      logic [2:0] m;
      case (code)
         FLOOR_1: m = up ? 3'b110 : 3'b000;
         FLOOR_2: m = up ? 3'b100 : 3'b001;
         FLOOR_3: m = up ? 3'b000 : 3'b011;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter with a final-tick flag, used for door dwell and floor travel.
// Latency: load/decrement visible one cycle later; no backpressure, enable simply freezes it.
module tick_counter
   import elevator_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // Flags the last tick: the next enabled decrement lands on zero.
   assign zero = (count <= W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/call_scheduler.sv
// Three-floor elevator call scheduler: latches calls, sweeps the car, times door and travel.
// Latency: all outputs registered, one cycle after the deciding edge; sos_mode freezes everything.
module call_scheduler
   import elevator_pkg::*;
#(
   parameter int DOOR_TICKS   = DOOR_TICKS_DEFAULT,
   parameter int TRAVEL_TICKS = TRAVEL_TICKS_DEFAULT
) (
   input  logic       clk,
   input  logic       button_reset,
   input  logic       call1,
   input  logic       call2,
   input  logic       call3,
   input  logic       sos_mode,
   input  logic       weight_limit_exceeded,
   output logic       led1,
   output logic       led2,
   output logic       led3,
   output logic       floor1,
   output logic       floor2,
   output logic       floor3,
   output logic       door,
   output logic       moving,
   output logic       dir_up,
   output logic [1:0] floor_code
);

   state_t     state, state_nx, saved, saved_nx;
   logic [2:0] pend, pend_nx, calls, here, arr_here;
   logic [1:0] pos, pos_nx, pos_step;
   logic       dir_nx, door_nx, moving_nx;
   logic       door_load, door_en, door_zero;
   logic       trav_load, trav_en, trav_zero;

   assign calls    = {call3, call2, call1};
   assign here     = floor_mask(pos);
   assign pos_step = dir_up ? ((pos == FLOOR_3) ? pos : pos + 2'd1)
                            : ((pos == FLOOR_1) ? pos : pos - 2'd1);
   assign arr_here = floor_mask(pos_step);

   assign {led3, led2, led1}       = pend;
   assign {floor3, floor2, floor1} = here;
   assign floor_code               = pos;

   tick_counter #(.W(CNT_W)) u_door_cnt (
      .clk      (clk),
      .rst      (button_reset),
      .load     (door_load),
      .en       (door_en),
      .load_val (CNT_W'(DOOR_TICKS)),
      .zero     (door_zero)
   );

   tick_counter #(.W(CNT_W)) u_travel_cnt (
      .clk      (clk),
      .rst      (button_reset),
      .load     (trav_load),
      .en       (trav_en),
      .load_val (CNT_W'(TRAVEL_TICKS)),
      .zero     (trav_zero)
   );

   always_ff @(posedge clk or posedge button_reset) begin
      if (button_reset) begin
         state  <= ST_IDLE;
         saved  <= ST_IDLE;
         pend   <= '0;
         pos    <= FLOOR_1;
         dir_up <= 1'b1;
         door   <= 1'b0;
         moving <= 1'b0;
      end else begin
         state  <= state_nx;
         saved  <= saved_nx;
         pend   <= pend_nx;
         pos    <= pos_nx;
         dir_up <= dir_nx;
         door   <= door_nx;
         moving <= moving_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      saved_nx  = saved;
      pend_nx   = pend | calls;
      pos_nx    = pos;
      dir_nx    = dir_up;
      door_load = 1'b0;
      door_en   = 1'b0;
      trav_load = 1'b0;
      trav_en   = 1'b0;
      // Emergency wins over every other transition; nothing advances on that edge.
      if (sos_mode && (state != ST_HOLD)) begin
         state_nx = ST_HOLD;
         saved_nx = state;
      end else begin
         case (state)
            ST_HOLD: begin
               if (!sos_mode) state_nx = saved;
            end
            ST_IDLE: begin
               pend_nx = pend | (calls & ~here);
               if (((pend | calls) & here) != '0) begin
                  state_nx  = ST_DOOR_OPEN;
                  door_load = 1'b1;
                  pend_nx   = pend_nx & ~here;
               end else if (!weight_limit_exceeded) begin
                  if ((pend & ahead_mask(pos, dir_up)) != '0) begin
                     state_nx  = ST_MOVING;
                     trav_load = 1'b1;
                  end else if ((pend & ahead_mask(pos, !dir_up)) != '0) begin
                     dir_nx    = !dir_up;
                     state_nx  = ST_MOVING;
                     trav_load = 1'b1;
                  end
               end
            end
            ST_DOOR_OPEN: begin
               pend_nx = pend | (calls & ~here);
               if (((calls & here) != '0) || weight_limit_exceeded) begin
                  door_load = 1'b1;
               end else begin
                  door_en = 1'b1;
                  if (door_zero) state_nx = ST_IDLE;
               end
            end
            default: begin
               trav_en = 1'b1;
               if (trav_zero) begin
                  pos_nx = pos_step;
                  dir_nx = (pos_step == FLOOR_3) ? 1'b0 :
                           (pos_step == FLOOR_1) ? 1'b1 : dir_up;
                  if (((pend | calls) & arr_here) != '0) begin
                     state_nx  = ST_DOOR_OPEN;
                     door_load = 1'b1;
                     pend_nx   = (pend | calls) & ~arr_here;
                  end else if (((pend | calls) & ahead_mask(pos_step, dir_up)) != '0) begin
                     trav_load = 1'b1;
                  end else begin
                     state_nx = ST_IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      door_nx   = (state_nx == ST_DOOR_OPEN);
      moving_nx = (state_nx == ST_MOVING);
   end

endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler with a floor-level behavioural model compared every cycle.
module tb_call_scheduler;

   localparam int DOOR_T   = 3;
   localparam int TRAVEL_T = 2;
   localparam int M_IDLE = 0, M_DOOR = 1, M_MOV = 2, M_HOLD = 3;

   logic       clk = 1'b0;
   logic       button_reset, call1, call2, call3, sos_mode, weight_limit_exceeded;
   logic       led1, led2, led3, floor1, floor2, floor3, door, moving, dir_up;
   logic [1:0] floor_code;

   int n_checks = 0;
   int n_errors = 0;

   call_scheduler #(.DOOR_TICKS(DOOR_T), .TRAVEL_TICKS(TRAVEL_T)) dut (
      .clk                   (clk),
      .button_reset          (button_reset),
      .call1                 (call1),
      .call2                 (call2),
      .call3                 (call3),
      .sos_mode              (sos_mode),
      .weight_limit_exceeded (weight_limit_exceeded),
      .led1                  (led1),
      .led2                  (led2),
      .led3                  (led3),
      .floor1                (floor1),
      .floor2                (floor2),
      .floor3                (floor3),
      .door                  (door),
      .moving                (moving),
      .dir_up                (dir_up),
      .floor_code            (floor_code)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model (floor numbers, remaining ticks) ----------------
   int       m_st, m_saved, m_floor, m_door, m_trav;
   bit       m_up;
   bit [3:1] m_pend;

   function automatic bit pend_toward(input bit [3:1] p, input int f, input bit up);
      for (int k = 1; k <= 3; k++)
         if (p[k] && (up ? (k > f) : (k < f))) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_saved = M_IDLE; m_floor = 1; m_up = 1'b1;
      m_pend = '0; m_door = 0; m_trav = 0;
   endtask

   task automatic model_step();
      bit [3:1] c, old;
      bit       up0;
      c   = {call3, call2, call1};
      old = m_pend;
      if (sos_mode && m_st != M_HOLD) begin
         m_saved = m_st;
         m_st    = M_HOLD;
         m_pend |= c;
      end else begin
         case (m_st)
            M_HOLD: begin
               m_pend |= c;
               if (!sos_mode) m_st = m_saved;
            end
            M_IDLE: begin
               for (int k = 1; k <= 3; k++) if (c[k] && k != m_floor) m_pend[k] = 1'b1;
               if (old[m_floor] || c[m_floor]) begin
                  m_pend[m_floor] = 1'b0; m_st = M_DOOR; m_door = DOOR_T;
               end else if (!weight_limit_exceeded) begin
                  if (!pend_toward(old, m_floor, m_up) && pend_toward(old, m_floor, !m_up)) m_up = !m_up;
                  if (pend_toward(old, m_floor, m_up)) begin m_st = M_MOV; m_trav = TRAVEL_T; end
               end
            end
            M_DOOR: begin
               for (int k = 1; k <= 3; k++) if (c[k] && k != m_floor) m_pend[k] = 1'b1;
               if (c[m_floor] || weight_limit_exceeded) m_door = DOOR_T;
               else begin
                  m_door--;
                  if (m_door == 0) m_st = M_IDLE;
               end
            end
            default: begin
               m_pend |= c;
               m_trav--;
               if (m_trav == 0) begin
                  up0 = m_up;
                  m_floor += up0 ? 1 : -1;
                  if (m_floor == 3) m_up = 1'b0; else if (m_floor == 1) m_up = 1'b1;
                  if (m_pend[m_floor]) begin
                     m_pend[m_floor] = 1'b0; m_st = M_DOOR; m_door = DOOR_T;
                  end else if (pend_toward(m_pend, m_floor, up0)) m_trav = TRAVEL_T;
                  else m_st = M_IDLE;
               end
            end
         endcase
      end
   endtask

   always @(posedge clk or posedge button_reset) begin
      if (button_reset) model_reset();
      else model_step();
   end

   logic [10:0] exp_v, act_v;
   always @(negedge clk) begin
      if (!button_reset) begin
         exp_v = {m_st == M_DOOR, m_st == M_MOV, m_floor == 3, m_floor == 2, m_floor == 1,
                  m_pend, m_up, 2'(m_floor)};
         act_v = {door, moving, floor3, floor2, floor1, led3, led2, led1, dir_up, floor_code};
         n_checks++;
         if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL model_cycle t=%0t: got %b expected %b", $time, act_v, exp_v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   int       mov_cnt, door_cnt, cyc;
   bit [2:0] led_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr();
      mov_cnt = 0; door_cnt = 0; cyc = 0; led_seen = '0;
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (moving) mov_cnt++;
      if (door) door_cnt++;
      led_seen |= {led3, led2, led1};
   endtask

   task automatic pulse(input logic [2:0] m);
      @(negedge clk); {call3, call2, call1} = m;
      @(negedge clk); {call3, call2, call1} = 3'b000;
   endtask

   int t_a, t_b, t_door;
   bit led3_at_door;

   initial begin
      button_reset = 1'b1;
      {call3, call2, call1} = 3'b000;
      sos_mode = 1'b0;
      weight_limit_exceeded = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_floor1", floor1, 1);
      check("rst_floor_code", floor_code, 1);
      check("rst_leds", {led3, led2, led1}, 0);
      check("rst_door_moving", {door, moving}, 0);
      check("rst_dir_up", dir_up, 1);
      button_reset = 1'b0;

      // call3 from floor 1: 4 moving cycles, floor2 at tick 3, floor3 at tick 5, door ticks 5..7
      pulse(3'b100);
      check("s1_led3_latched", led3, 1);
      clr(); t_a = 0; t_b = 0; t_door = 0; led3_at_door = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (floor2 && t_a == 0) t_a = i;
         if (floor3 && t_b == 0) t_b = i;
         if (door && t_door == 0) begin t_door = i; led3_at_door = led3; end
      end
      check("s1_moving_cycles", mov_cnt, 4);
      check("s1_door_cycles", door_cnt, 3);
      check("s1_floor2_tick", t_a, 3);
      check("s1_floor3_tick", t_b, 5);
      check("s1_door_rise_tick", t_door, 5);
      check("s1_led3_clear_at_door", led3_at_door, 0);

      // at floor 3 heading down, calls 1 and 2: stop at 2 first
      check("s2_dir_down_at_top", dir_up, 0);
      pulse(3'b011);
      clr(); t_a = 0; t_b = 0;
      for (int i = 1; i <= 18; i++) begin
         tick();
         if (!led2 && t_a == 0) t_a = i;
         if (!led1 && t_b == 0) t_b = i;
      end
      check("s2_led2_clear_tick", t_a, 3);
      check("s2_led1_clear_tick", t_b, 9);
      check("s2_door_cycles", door_cnt, 6);
      check("s2_moving_cycles", mov_cnt, 4);
      check("s2_at_floor1", {floor3, floor2, floor1}, 3'b001);

      // door re-open at floor 1 by call1 in the 2nd door cycle
      pulse(3'b001);
      check("s3_door_opened", door, 1);
      clr();
      tick(); call1 = 1'b1;
      tick(); call1 = 1'b0;
      repeat (8) tick();
      check("s3_door_cycles_after_first", door_cnt, 4);
      check("s3_led1_never", led_seen[0], 0);

      // overload for 5 cycles during door, call2 latched meanwhile
      pulse(3'b001);
      weight_limit_exceeded = 1'b1;
      clr();
      tick(); call2 = 1'b1;
      tick(); call2 = 1'b0;
      repeat (3) tick();
      weight_limit_exceeded = 1'b0;
      check("s4_no_move_while_heavy", mov_cnt, 0);
      repeat (2) tick();
      check("s4_door_still_open_t7", door, 1);
      tick();
      check("s4_door_closed_t8", door, 0);
      check("s4_door_cycles", door_cnt, 7);
      repeat (8) tick();
      check("s4_served_floor2", {floor2, led2, door}, 3'b100);

      // overload in IDLE blocks departure
      weight_limit_exceeded = 1'b1;
      pulse(3'b100);
      clr();
      repeat (5) tick();
      check("s5_no_move_in_idle", mov_cnt, 0);
      check("s5_led3_pending", led3, 1);
      weight_limit_exceeded = 1'b0;
      tick();
      check("s5_moves_after_release", moving, 1);
      repeat (6) tick();

      // sos mid-travel between floors 1 and 2
      @(negedge clk); button_reset = 1'b1;
      @(negedge clk); button_reset = 1'b0;
      pulse(3'b100);
      tick(); tick();
      sos_mode = 1'b1;
      tick();
      check("s6_hold_outputs", {door, moving, floor1}, 3'b001);
      pulse(3'b010);
      check("s6_call2_latched_in_hold", led2, 1);
      sos_mode = 1'b0;
      tick();
      check("s6_resumed_moving", {moving, floor1}, 2'b11);
      tick();
      check("s6_remaining_tick_arrival", {door, floor2, led2}, 3'b110);

      // asynchronous reset while moving towards floor 3
      t_a = 0;
      for (int i = 0; i < 20 && t_a == 0; i++) begin
         tick();
         if (moving) t_a = 1;
      end
      check("s7_reached_moving", t_a, 1);
      check("s7_led3_pending", led3, 1);
      @(posedge clk);
      #2 button_reset = 1'b1;
      #1;
      check("s7_async_floor", {floor3, floor2, floor1, floor_code}, 5'b00101);
      check("s7_async_leds", {led3, led2, led1}, 0);
      check("s7_async_door_moving", {door, moving}, 0);
      @(negedge clk); button_reset = 1'b0;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/call_scheduler.md
CALL_SCHEDULER -- requirements
Module: call_scheduler

Interface
REQ-001 Parameter DOOR_TICKS, default 3: number of clk cycles the door stays open per stop.
REQ-002 Parameter TRAVEL_TICKS, default 2: number of clk cycles per one-floor move.
REQ-003 Port clk, input, 1: slow system clock from frequency; all state updates on its rising edge.
REQ-004 Port button_reset, input, 1: reset, asynchronous, active-high.
REQ-005 Ports call1/call2/call3, input, 1 each: debounced one-cycle call pulses from button_handler.
REQ-006 Port sos_mode, input, 1: emergency hold request from emergency.
REQ-007 Port weight_limit_exceeded, input, 1: overload flag from emergency.
REQ-008 Ports led1/led2/led3, output, 1 each: pending-call indicators.
REQ-009 Ports floor1/floor2/floor3, output, 1 each: car position, one-hot.
REQ-010 Port door, output, 1: door open.
REQ-011 Port moving, output, 1: car travelling.
REQ-012 Port dir_up, output, 1: current sweep direction, 1 = up.
REQ-013 Port floor_code, output, 2: binary position 1..3, for the display decoder.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, DOOR_OPEN, MOVING, HOLD.
REQ-015 A callk pulse SHALL set pend[k], except at the current floor in IDLE or DOOR_OPEN, where it SHALL open or re-open the door instead.
REQ-016 ledk SHALL equal pend[k], registered, with no combinational path from callk.
REQ-017 IDLE transitions:
- pend at current floor: go to DOOR_OPEN next cycle.
- pend ahead in the dir_up direction: go to MOVING.
- pend only behind: toggle dir_up, then go to MOVING in the same transition.
- no pend: stay in IDLE.
REQ-018 On entry to MOVING, and on each floor pass, the travel counter SHALL load TRAVEL_TICKS and decrement once per cycle.
REQ-019 When the travel counter reaches 0, position SHALL change by one floor in the dir_up direction.
REQ-020 On arrival at floor k with pend[k]=1, the FSM SHALL go to DOOR_OPEN and clear pend[k] in the same cycle.
REQ-021 On arrival with pend[k]=0, the FSM SHALL stay in MOVING if pend remains ahead, else go to IDLE.
REQ-022 Position SHALL saturate at floors 1 and 3, with dir_up forced to 0 at floor 3 and to 1 at floor 1.
REQ-023 DOOR_OPEN SHALL load the door counter with DOOR_TICKS and decrement it once per cycle, going to IDLE when it reaches 0.
REQ-024 While weight_limit_exceeded=1 in DOOR_OPEN, the door counter SHALL hold at DOOR_TICKS, so the door closes DOOR_TICKS cycles after the flag drops.
REQ-025 weight_limit_exceeded=1 in IDLE SHALL inhibit the IDLE-to-MOVING transition.
REQ-026 sos_mode=1 in any state SHALL enter HOLD on the next edge.
REQ-027 HOLD SHALL save the prior state and freeze counters and position; calls SHALL still latch.
REQ-028 On sos_mode=0, HOLD SHALL return to the saved state with the counters resumed unchanged.
REQ-029 Outputs are registered:
- door=1 only in DOOR_OPEN.
- moving=1 only in MOVING.
- HOLD drives door=0 and moving=0.
REQ-030 A callk coincident with arrival at floor k SHALL be treated as that arrival: pend[k] ends at 0.
REQ-031 A call for the floor just departed in MOVING SHALL latch normally.

Reset
REQ-032 button_reset=1 SHALL immediately force the following, regardless of clk:
- state=IDLE, saved state=IDLE;
- pend=000, position=floor 1 (floor1=1, floor_code=01);
- dir_up=1, both counters=0;
- door=0, moving=0.
REQ-033 Reset mid-MOVING or mid-DOOR_OPEN SHALL discard all pending calls.
REQ-034 The first state change SHALL occur on the first clk edge after reset deasserts.

Structure
REQ-035 The state encoding, floor codes 01/10/11 and the DOOR_TICKS/TRAVEL_TICKS defaults SHALL live in shared package elevator_pkg.
REQ-036 The door and travel counters SHALL each be an instance of one sub-module, tick_counter, with load, enable, zero-flag and asynchronous reset.
REQ-037 Target size is 120-400 RTL lines total.

Verification (DOOR_TICKS=3, TRAVEL_TICKS=2)
REQ-038 Reset, then call3 pulse -> led3=1; moving=1 for exactly 4 cycles; floor2 then floor3; door=1 for 3 cycles; led3=0 on the cycle door rises.
REQ-039 Car at floor 3, calls 1 and 2 pending -> dir_up=0; stop at floor 2 (door 3 cycles); then floor 1; led2 clears before led1.
REQ-040 DOOR_OPEN at floor 1, call1 pulse on the 2nd door cycle -> door stays high 3 more cycles; led1 never asserts.
REQ-041 weight_limit_exceeded=1 for 5 cycles during DOOR_OPEN -> door high for those 5 cycles plus 3 after; no MOVING entry while the flag is high.
REQ-042 sos_mode=1 mid-travel between floors 1 and 2 -> HOLD, door=0, moving=0, position frozen; call2 latches; on release, MOVING resumes with the remaining ticks.
REQ-043 button_reset pulse mid-MOVING with led3=1 -> outputs reset to floor1=1, led=000, door=0, moving=0, without waiting for a clk edge.
